// File: rtl/line_list_sequencer.sv
// line_list_sequencer: walks a display list of line segments held in a
// synchronous ROM and launches each entry into the line-drawing core through a
// start/done handshake, frame after frame, with run/stop control, a frame-done
// pulse and a programmable inter-frame gap.
// Optional full-screen clear pass ahead of every frame: define LINE_SEQ_CLEAR_EN.
module line_list_sequencer #(
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int AW        = 12,
    parameter int N_ENTRIES = 600,
    parameter int ROM_LAT   = 2,
    parameter int FRAME_GAP = 16,
    parameter int XMAX      = 639,
    parameter int YMAX      = 479
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic [AW-1:0]          rom_addr,
    input  logic [2*XW+2*YW:0]     rom_data,
    output logic                   ld_start,
    output logic [XW-1:0]          ld_x0,
    output logic [XW-1:0]          ld_x1,
    output logic [YW-1:0]          ld_y0,
    output logic [YW-1:0]          ld_y1,
    output logic                   ld_color,
    input  logic                   ld_done,
    output logic                   clr_we,
    output logic [XW-1:0]          clr_x,
    output logic [YW-1:0]          clr_y,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int              DW        = 1 + 2*XW + 2*YW;
    // A zero gap still spends one cycle in GAP.
    localparam int              GAP_CYC   = (FRAME_GAP == 0) ? 1 : FRAME_GAP;
    localparam int              GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(N_ENTRIES - 1);
    localparam logic [2:0]      WAIT_LOAD = 3'(ROM_LAT - 1);
    localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef LINE_SEQ_CLEAR_EN
        CLEAR,
`endif
        FETCH,
        WAIT,
        LAUNCH,
        DRAW,
        NEXT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [2:0]      wait_q, wait_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            ld_start_q, ld_start_d;
    logic            frame_done_q, frame_done_d;
    logic            ld_color_q, ld_color_d;
    logic [XW-1:0]   ld_x0_q, ld_x0_d;
    logic [XW-1:0]   ld_x1_q, ld_x1_d;
    logic [YW-1:0]   ld_y0_q, ld_y0_d;
    logic [YW-1:0]   ld_y1_q, ld_y1_d;

    // ROM word fields, MSB first: {color, x0, y0, x1, y1}
    logic            seg_color;
    logic [XW-1:0]   seg_x0, seg_x1;
    logic [YW-1:0]   seg_y0, seg_y1;

    assign seg_color = rom_data[DW-1];
    assign seg_x0    = rom_data[2*YW+2*XW-1 : 2*YW+XW];
    assign seg_y0    = rom_data[2*YW+XW-1   : YW+XW];
    assign seg_x1    = rom_data[YW+XW-1     : YW];
    assign seg_y1    = rom_data[YW-1        : 0];

`ifdef LINE_SEQ_CLEAR_EN
    localparam logic [XW-1:0] CLR_XLAST = XW'(XMAX);
    localparam logic [YW-1:0] CLR_YLAST = YW'(YMAX);

    logic [XW-1:0]   clr_x_q, clr_x_d;
    logic [YW-1:0]   clr_y_q, clr_y_d;
`endif

    // State and sequencing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            gap_q        <= '0;
            ld_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            gap_q        <= gap_d;
            ld_start_q   <= ld_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Segment registers presented to the line drawer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_color_q <= 1'b0;
            ld_x0_q    <= '0;
            ld_y0_q    <= '0;
            ld_x1_q    <= '0;
            ld_y1_q    <= '0;
        end else begin
            ld_color_q <= ld_color_d;
            ld_x0_q    <= ld_x0_d;
            ld_y0_q    <= ld_y0_d;
            ld_x1_q    <= ld_x1_d;
            ld_y1_q    <= ld_y1_d;
        end
    end

`ifdef LINE_SEQ_CLEAR_EN
    // Clear-pass raster position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
        end else begin
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
        end
    end
`endif

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        // ld_start is registered, so it appears in the first DRAW cycle
        // together with the freshly captured endpoints.
        ld_start_d   = (state_q == LAUNCH);
        ld_color_d   = ld_color_q;
        ld_x0_d      = ld_x0_q;
        ld_y0_d      = ld_y0_q;
        ld_x1_d      = ld_x1_q;
        ld_y1_d      = ld_y1_q;
`ifdef LINE_SEQ_CLEAR_EN
        clr_x_d      = clr_x_q;
        clr_y_d      = clr_y_q;
`endif

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (enable) begin
`ifdef LINE_SEQ_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = FETCH;
`endif
                end
            end

`ifdef LINE_SEQ_CLEAR_EN
            CLEAR: begin
                if (clr_x_q == CLR_XLAST) begin
                    clr_x_d = '0;
                    if (clr_y_q == CLR_YLAST) begin
                        clr_y_d = '0;
                        state_d = FETCH;
                    end else begin
                        clr_y_d = clr_y_q + YW'(1);
                    end
                end else begin
                    clr_x_d = clr_x_q + XW'(1);
                end
            end
`endif

            FETCH: begin
                wait_d  = WAIT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = LAUNCH;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end

            LAUNCH: begin
                ld_color_d = seg_color;
                ld_x0_d    = seg_x0;
                ld_y0_d    = seg_y0;
                ld_x1_d    = seg_x1;
                ld_y1_d    = seg_y1;
                state_d    = DRAW;
            end

            DRAW: begin
                if (ld_done) begin
                    state_d = NEXT;
                end
            end

            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                    gap_d        = GAP_LOAD;
                    state_d      = GAP;
                end else if (!enable) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = FETCH;
                end
            end

            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr   = idx_q;
    assign ld_start   = ld_start_q;
    assign ld_color   = ld_color_q;
    assign ld_x0      = ld_x0_q;
    assign ld_y0      = ld_y0_q;
    assign ld_x1      = ld_x1_q;
    assign ld_y1      = ld_y1_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

`ifdef LINE_SEQ_CLEAR_EN
    assign clr_we = (state_q == CLEAR);
    assign clr_x  = clr_x_q;
    assign clr_y  = clr_y_q;
`else
    // Clear extents only matter when the clear pass is built in.
    logic unused_clr_cfg;
    assign unused_clr_cfg = (XMAX == YMAX);
    assign clr_we = 1'b0;
    assign clr_x  = '0;
    assign clr_y  = '0;
`endif

endmodule

// File: tb/tb_line_list_sequencer.sv
// Directed bench for line_list_sequencer: four instances with different
// ROM latency / list length / gap settings, each with its own ROM and drawer model.
module tb_line_list_sequencer;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int AW = 12;
    localparam int DW = 1 + 2*XW + 2*YW;
`ifdef LINE_SEQ_CLEAR_EN
    localparam int CLR = 8;
`else
    localparam int CLR = 0;
`endif

    function automatic int lat_of(input int g);
        case (g)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int n_of(input int g);
        case (g)
            0:       return 600;
            3:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int gap_of(input int g);
        return (g == 0) ? 16 : 0;
    endfunction

    function automatic logic [DW-1:0] romw(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        romw = {1'(ai ^ (ai >> 3)), XW'(ai*7 + 3), YW'(ai*5 + 1),
                XW'(ai*13 + 100), YW'(ai*11 + 7)};
    endfunction

    logic            clk;
    logic            rst;
    logic [3:0]      en;
    logic [3:0]      hold;
    logic [3:0]      ld_start, ld_done, ld_color, clr_we, frame_done, busy;
    logic [AW-1:0]   rom_addr [4];
    logic [DW-1:0]   rom_data [4];
    logic [XW-1:0]   ld_x0 [4];
    logic [XW-1:0]   ld_x1 [4];
    logic [YW-1:0]   ld_y0 [4];
    logic [YW-1:0]   ld_y1 [4];
    logic [XW-1:0]   clr_x [4];
    logic [YW-1:0]   clr_y [4];

    int checks = 0;
    int errors = 0;
    int fd_cnt [4];
    int coinc  [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int L = lat_of(g);
        logic [DW-1:0] pipe [4];
        logic [2:0]    dcnt;

        always_ff @(posedge clk) begin
            pipe[0] <= romw(rom_addr[g]);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            if (rst)               dcnt <= 3'd0;
            else if (ld_start[g])  dcnt <= 3'd5;
            else if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
        end

        assign rom_data[g] = pipe[L-1];
        assign ld_done[g]  = hold[g] | (dcnt == 3'd1);

        line_list_sequencer #(
            .XW(XW), .YW(YW), .AW(AW),
            .N_ENTRIES(n_of(g)), .ROM_LAT(L), .FRAME_GAP(gap_of(g)),
            .XMAX(3), .YMAX(1)
        ) dut (
            .clk(clk), .reset(rst), .enable(en[g]),
            .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
            .ld_start(ld_start[g]),
            .ld_x0(ld_x0[g]), .ld_x1(ld_x1[g]), .ld_y0(ld_y0[g]), .ld_y1(ld_y1[g]),
            .ld_color(ld_color[g]), .ld_done(ld_done[g]),
            .clr_we(clr_we[g]), .clr_x(clr_x[g]), .clr_y(clr_y[g]),
            .frame_done(frame_done[g]), .busy(busy[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (frame_done[k] === 1'b1)                      fd_cnt[k] <= fd_cnt[k] + 1;
            if (frame_done[k] === 1'b1 && ld_start[k] === 1'b1) coinc[k] <= coinc[k] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int i, input int lim, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < lim && !ok) begin
            tick();
            n++;
            if (ld_start[i] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_fd(input int i, input int lim, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < lim && !ok) begin
            tick();
            n++;
            if (frame_done[i] === 1'b1) ok = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] seg_of(input int i);
        return {ld_color[i], ld_x0[i], ld_y0[i], ld_x1[i], ld_y1[i]};
    endfunction

    task automatic test_reset();
        tick();
        tick();
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
        checks++; if (rom_addr[0] !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr[0]); end
        checks++; if (ld_start !== 4'b0000) begin errors++; $display("FAIL reset_ld_start got %b want 0000", ld_start); end
        checks++; if (frame_done !== 4'b0000) begin errors++; $display("FAIL reset_frame_done got %b want 0000", frame_done); end
        checks++; if (seg_of(0) !== '0) begin errors++; $display("FAIL reset_seg got %h want 0", seg_of(0)); end
        checks++; if (clr_we !== 4'b0000 || clr_x[0] !== '0 || clr_y[0] !== '0) begin
            errors++; $display("FAIL reset_clr got we=%b x=%0d y=%0d want 0", clr_we, clr_x[0], clr_y[0]); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (busy[0] !== 1'b0 || rom_addr[0] !== '0) begin
            errors++; $display("FAIL idle_hold got busy=%b addr=%0d want 0/0", busy[0], rom_addr[0]); end
    endtask

    task automatic test_clear();
        en[0] = 1'b1;
`ifdef LINE_SEQ_CLEAR_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (clr_we[0] !== 1'b1 || clr_x[0] !== XW'(k % 4) || clr_y[0] !== YW'(k / 4) || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL clear_px%0d got we=%b x=%0d y=%0d want 1 %0d %0d", k, clr_we[0], clr_x[0], clr_y[0], k % 4, k / 4);
            end
        end
`endif
        tick();
        checks++; if (clr_we[0] !== 1'b0 || busy[0] !== 1'b1 || rom_addr[0] !== '0) begin
            errors++; $display("FAIL fetch0 got we=%b busy=%b addr=%0d want 0 1 0", clr_we[0], busy[0], rom_addr[0]); end
        checks++; if (clr_x[0] !== '0 || clr_y[0] !== '0) begin
            errors++; $display("FAIL clr_idle_xy got %0d,%0d want 0,0", clr_x[0], clr_y[0]); end
    endtask

    task automatic test_full_frame();
        int n;
        bit ok;
        for (int k = 0; k < 600; k++) begin
            wait_start(0, 40, n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL frame_start%0d got timeout want ld_start", k); break; end
            checks++; if (n !== ((k == 0) ? 4 : 11)) begin
                errors++; $display("FAIL frame_spacing%0d got %0d want %0d", k, n, (k == 0) ? 4 : 11); end
            checks++; if (rom_addr[0] !== AW'(k)) begin
                errors++; $display("FAIL frame_addr%0d got %0d want %0d", k, rom_addr[0], k); end
            checks++; if (seg_of(0) !== romw(AW'(k))) begin
                errors++; $display("FAIL frame_seg%0d got %h want %h", k, seg_of(0), romw(AW'(k))); end
        end
        checks++; if (fd_cnt[0] !== 0) begin errors++; $display("FAIL early_frame_done got %0d want 0", fd_cnt[0]); end
        wait_fd(0, 20, n, ok);
        checks++; if (!ok || n !== 7) begin errors++; $display("FAIL frame_done_lat got %0d ok=%0d want 7", n, ok); end
        repeat (15) tick();
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL gap_len_busy got %b want 1", busy[0]); end
        tick();
        checks++; if (busy[0] !== 1'b0 || rom_addr[0] !== '0) begin
            errors++; $display("FAIL gap_end got busy=%b addr=%0d want 0 0", busy[0], rom_addr[0]); end
        checks++; if (fd_cnt[0] !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_cnt[0]); end
        wait_start(0, 40, n, ok);
        checks++; if (!ok || n !== 5 + CLR || rom_addr[0] !== '0) begin
            errors++; $display("FAIL frame2_start got n=%0d addr=%0d want %0d 0", n, rom_addr[0], 5 + CLR); end
    endtask

    task automatic test_stop_restart();
        int n;
        int cnt;
        bit ok;
        for (int k = 1; k <= 7; k++) wait_start(0, 40, n, ok);
        checks++; if (!ok || rom_addr[0] !== AW'(7)) begin
            errors++; $display("FAIL stop_entry7 got addr=%0d ok=%0d want 7", rom_addr[0], ok); end
        en[0] = 1'b0;
        repeat (4) tick();
        checks++; if (seg_of(0) !== romw(AW'(7)) || ld_start[0] !== 1'b0) begin
            errors++; $display("FAIL draw_hold got %h st=%b want %h 0", seg_of(0), ld_start[0], romw(AW'(7))); end
        repeat (2) tick();
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL stop_next_busy got %b want 1", busy[0]); end
        tick();
        checks++; if (busy[0] !== 1'b0 || rom_addr[0] !== '0) begin
            errors++; $display("FAIL stop_idle got busy=%b addr=%0d want 0 0", busy[0], rom_addr[0]); end
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ld_start[0] === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL stopped_starts got %0d want 0", cnt); end
        en[0] = 1'b1;
        wait_start(0, 40, n, ok);
        checks++; if (!ok || n !== 5 + CLR || rom_addr[0] !== '0) begin
            errors++; $display("FAIL restart got n=%0d addr=%0d want %0d 0", n, rom_addr[0], 5 + CLR); end
        checks++; if (seg_of(0) !== romw('0)) begin
            errors++; $display("FAIL restart_seg got %h want %h", seg_of(0), romw('0)); end
    endtask

    task automatic test_reset_mid_draw();
        int n;
        bit ok;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ld_start[0] !== 1'b0) begin errors++; $display("FAIL rst_ld_start got %b want 0", ld_start[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy[0]); end
        checks++; if (seg_of(0) !== '0 || rom_addr[0] !== '0 || frame_done[0] !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got seg=%h addr=%0d fd=%b want 0", seg_of(0), rom_addr[0], frame_done[0]); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_start(0, 40, n, ok);
        checks++; if (!ok || n !== 5 + CLR || rom_addr[0] !== '0) begin
            errors++; $display("FAIL post_rst_start got n=%0d addr=%0d want %0d 0", n, rom_addr[0], 5 + CLR); end
        en[0] = 1'b0;
        repeat (20) tick();
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b want 0", busy[0]); end
    endtask

    task automatic test_lat_spacing();
        int n;
        bit ok;
        for (int i = 1; i <= 2; i++) begin
            en[i] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                wait_start(i, 60, n, ok);
                checks++; if (!ok || n !== ((k == 0) ? lat_of(i) + 3 + CLR : 9 + lat_of(i))) begin
                    errors++; $display("FAIL lat%0d_spacing%0d got %0d want %0d", lat_of(i), k, n,
                                       (k == 0) ? lat_of(i) + 3 + CLR : 9 + lat_of(i)); end
                checks++; if (rom_addr[i] !== AW'(k) || seg_of(i) !== romw(AW'(k))) begin
                    errors++; $display("FAIL lat%0d_entry%0d got addr=%0d seg=%h want %0d %h", lat_of(i), k,
                                       rom_addr[i], seg_of(i), k, romw(AW'(k))); end
            end
            wait_fd(i, 20, n, ok);
            checks++; if (!ok || n !== 7) begin errors++; $display("FAIL lat%0d_fd got %0d want 7", lat_of(i), n); end
            tick();
            checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL gap0_len got busy=%b want 0", busy[i]); end
            en[i] = 1'b0;
            tick();
            checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL lat%0d_park got %b want 0", lat_of(i), busy[i]); end
        end
    endtask

    task automatic test_single_entry();
        int n;
        int base;
        bit ok;
        base = fd_cnt[3];
        en[3] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_start(3, 40, n, ok);
            checks++; if (!ok || n !== ((f == 0) ? 5 + CLR : 6 + CLR)) begin
                errors++; $display("FAIL single_start%0d got %0d want %0d", f, n, (f == 0) ? 5 + CLR : 6 + CLR); end
            checks++; if (rom_addr[3] !== '0 || seg_of(3) !== romw('0)) begin
                errors++; $display("FAIL single_seg%0d got addr=%0d seg=%h want 0 %h", f, rom_addr[3], seg_of(3), romw('0)); end
            wait_fd(3, 20, n, ok);
            checks++; if (!ok || n !== 2) begin errors++; $display("FAIL single_fd%0d got %0d want 2", f, n); end
        end
        en[3] = 1'b0;
        tick();
        checks++; if (fd_cnt[3] - base !== 3) begin errors++; $display("FAIL single_fd_count got %0d want 3", fd_cnt[3] - base); end
    endtask

    task automatic test_no_overlap();
        for (int k = 0; k < 4; k++) begin
            checks++; if (coinc[k] !== 0) begin
                errors++; $display("FAIL overlap%0d got %0d want 0", k, coinc[k]); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 4'b0000;
        hold = 4'b1000;
        test_reset();
        test_clear();
        test_full_frame();
        test_stop_restart();
        test_reset_mid_draw();
        test_lat_spacing();
        test_single_entry();
        test_no_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
